// File: rtl/reg_writeback_arbiter.sv
// Register-file write-port arbiter: ALU results win, loads queue in a small FIFO,
// pending-write scoreboard drives hazard. Optional WB_BYPASS_EN adds byp_sel forwarding.
module reg_writeback_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int QDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      alu_valid,
  input  logic [ADDR_W-1:0]         alu_rd,
  input  logic [DATA_W-1:0]         alu_data,
  input  logic                      mem_valid,
  output logic                      mem_ready,
  input  logic [ADDR_W-1:0]         mem_rd,
  input  logic [DATA_W-1:0]         mem_data,
  input  logic                      iss_valid,
  input  logic [ADDR_W-1:0]         iss_rd,
  input  logic [ADDR_W-1:0]         RS1,
  input  logic [ADDR_W-1:0]         RS2,
  input  logic [ADDR_W-1:0]         RS3,
  output logic                      hazard,
  output logic [ADDR_W-1:0]         RD,
  output logic [DATA_W-1:0]         WD,
  output logic                      wr_enable,
  output logic [$clog2(QDEPTH):0]   q_count
`ifdef WB_BYPASS_EN
  ,
  output logic [2:0]                byp_sel
`endif
);

  localparam int PW   = $clog2(QDEPTH);
  localparam int CW   = PW + 1;
  localparam int NREG = 1 << ADDR_W;

  logic [ADDR_W-1:0] r_q_rd   [QDEPTH];
  logic [DATA_W-1:0] r_q_data [QDEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic [NREG-1:0]   r_pend;
  logic [ADDR_W-1:0] r_rd;
  logic [DATA_W-1:0] r_wd;
  logic              r_we;

  logic              w_push;
  logic              w_pop;
  logic              w_sel;
  logic [ADDR_W-1:0] w_sel_rd;
  logic [DATA_W-1:0] w_sel_data;
  logic [NREG-1:0]   w_set;
  logic [NREG-1:0]   w_clr;
  logic [2:0]        w_pend_rs;

  // No credit is given for a pop in the same cycle.
  assign mem_ready = (r_count < CW'(QDEPTH));
  assign w_push    = mem_valid && mem_ready && !flush;
  assign w_pop     = w_sel && !alu_valid;
  assign q_count   = r_count;

  always_comb begin
    w_sel      = 1'b0;
    w_sel_rd   = '0;
    w_sel_data = '0;
    if (!flush) begin
      if (alu_valid) begin
        w_sel      = 1'b1;
        w_sel_rd   = alu_rd;
        w_sel_data = alu_data;
      end else if (r_count != '0) begin
        w_sel      = 1'b1;
        w_sel_rd   = r_q_rd[r_rptr];
        w_sel_data = r_q_data[r_rptr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_rd[r_wptr]   <= mem_rd;
      r_q_data[r_wptr] <= mem_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A destination of 0 still consumes the result but never strobes the port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd <= '0;
      r_wd <= '0;
      r_we <= 1'b0;
    end else begin
      r_we <= w_sel && (w_sel_rd != '0);
      if (w_sel) begin
        r_rd <= w_sel_rd;
        r_wd <= w_sel_data;
      end
    end
  end

  assign RD        = r_rd;
  assign WD        = r_wd;
  assign wr_enable = r_we;

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (iss_valid && (iss_rd != '0)) w_set[iss_rd] = 1'b1;
    if (r_we)                        w_clr[r_rd]   = 1'b1;
  end

  // Set is OR-ed after the clear so a same-edge reissue keeps the bit pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend <= '0;
    end else if (flush) begin
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_set;
    end
  end

  assign w_pend_rs = {r_pend[RS3], r_pend[RS2], r_pend[RS1]};

`ifdef WB_BYPASS_EN
  logic [2:0] w_byp;

  always_comb begin
    w_byp    = 3'b000;
    w_byp[0] = r_we && (r_rd != '0) && (r_rd == RS1);
    w_byp[1] = r_we && (r_rd != '0) && (r_rd == RS2);
    w_byp[2] = r_we && (r_rd != '0) && (r_rd == RS3);
  end

  assign byp_sel = w_byp;
  assign hazard  = |(w_pend_rs & ~w_byp);
`else
  assign hazard  = |w_pend_rs;
`endif

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Scenario bench for reg_writeback_arbiter: a behavioural model predicts each write-port
// result into a queue; every cycle the DUT's write port, ready, occupancy and hazard are compared.
module tb_reg_writeback_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int QDEPTH = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic              alu_valid = 1'b0;
  logic [ADDR_W-1:0] alu_rd = '0;
  logic [DATA_W-1:0] alu_data = '0;
  logic              mem_valid = 1'b0;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_rd = '0;
  logic [DATA_W-1:0] mem_data = '0;
  logic              iss_valid = 1'b0;
  logic [ADDR_W-1:0] iss_rd = '0;
  logic [ADDR_W-1:0] RS1 = '0;
  logic [ADDR_W-1:0] RS2 = '0;
  logic [ADDR_W-1:0] RS3 = '0;
  logic              hazard;
  logic [ADDR_W-1:0] RD;
  logic [DATA_W-1:0] WD;
  logic              wr_enable;
  logic [2:0]        q_count;
`ifdef WB_BYPASS_EN
  logic [2:0]        byp_sel;
`endif

  always #5 clk = ~clk;

  reg_writeback_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .RS1(RS1), .RS2(RS2), .RS3(RS3), .hazard(hazard),
    .RD(RD), .WD(WD), .wr_enable(wr_enable), .q_count(q_count)
`ifdef WB_BYPASS_EN
    , .byp_sel(byp_sel)
`endif
  );

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] d;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mq[$];
  logic [15:0] m_pend = '0;
  logic        m_we = 1'b0;
  logic [3:0]  m_rd = '0;
  logic        last_acc = 1'b0;
  int          total = 0;
  int          bad = 0;

  task automatic model_reset();
    exp_q.delete();
    mq.delete();
    m_pend = '0;
    m_we   = 1'b0;
    m_rd   = '0;
  endtask

  task automatic idle_inputs();
    flush = 0; alu_valid = 0; mem_valid = 0; iss_valid = 0;
  endtask

  // One clock: compare DUT against the model mid-cycle, advance the model, cross the edge.
  task automatic cycle();
    logic       exp_rdy, exp_haz;
    logic [3:0] rs [3];
    wr_t        w, sel;
    logic       have;
    @(negedge clk);
    exp_rdy = (mq.size() < QDEPTH);
    rs[0] = RS1; rs[1] = RS2; rs[2] = RS3;
    exp_haz = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (m_pend[rs[i]]) begin
`ifdef WB_BYPASS_EN
        if (!(m_we && m_rd == rs[i])) exp_haz = 1'b1;
`else
        exp_haz = 1'b1;
`endif
      end
    end
    total++;
    if (mem_ready !== exp_rdy) begin
      bad++; $display("FAIL mem_ready got=%b exp=%b t=%0t", mem_ready, exp_rdy, $time);
    end
    total++;
    if (q_count !== 3'(mq.size())) begin
      bad++; $display("FAIL q_count got=%0d exp=%0d t=%0t", q_count, mq.size(), $time);
    end
    total++;
    if (hazard !== exp_haz) begin
      bad++; $display("FAIL hazard got=%b exp=%b RS=%0d/%0d/%0d t=%0t", hazard, exp_haz, RS1, RS2, RS3, $time);
    end
    total++;
    if (wr_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL wb_extra got RD=%0d WD=%h exp no write t=%0t", RD, WD, $time);
      end else begin
        w = exp_q.pop_front();
        if (RD !== w.rd || WD !== w.d) begin
          bad++; $display("FAIL wb_data got RD=%0d WD=%h exp RD=%0d WD=%h t=%0t", RD, WD, w.rd, w.d, $time);
        end
      end
    end else if (exp_q.size() != 0) begin
      w = exp_q.pop_front();
      bad++; $display("FAIL wb_missing got wr_enable=%b exp RD=%0d WD=%h t=%0t", wr_enable, w.rd, w.d, $time);
    end
    last_acc = mem_valid && exp_rdy;
    if (flush) begin
      mq.delete();
      m_pend   = '0;
      m_we     = 1'b0;
      last_acc = 1'b0;
    end else begin
      have = 1'b0;
      sel  = '0;
      if (m_we) m_pend[m_rd] = 1'b0;
      if (iss_valid && iss_rd != 0) m_pend[iss_rd] = 1'b1;
      if (alu_valid) begin
        sel.rd = alu_rd; sel.d = alu_data; have = 1'b1;
      end else if (mq.size() != 0) begin
        sel = mq.pop_front(); have = 1'b1;
      end
      if (last_acc) mq.push_back(wr_t'({mem_rd, mem_data}));
      m_we = have && (sel.rd != 0);
      if (m_we) begin
        m_rd = sel.rd;
        exp_q.push_back(sel);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 0; idle_inputs(); model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (RD !== 4'd0)        begin bad++; $display("FAIL rst_RD got=%0d exp=0", RD); end
    total++; if (WD !== 32'd0)       begin bad++; $display("FAIL rst_WD got=%h exp=0", WD); end
    total++; if (wr_enable !== 1'b0) begin bad++; $display("FAIL rst_we got=%b exp=0", wr_enable); end
    total++; if (q_count !== 3'd0)   begin bad++; $display("FAIL rst_qcount got=%0d exp=0", q_count); end
    total++; if (mem_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", mem_ready); end
    total++; if (hazard !== 1'b0)    begin bad++; $display("FAIL rst_hazard got=%b exp=0", hazard); end
    rst = 1;
    repeat (10) cycle();
  endtask

  task automatic test_alu_single();
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    cycle();
    alu_valid = 0;
    total++;
    if (wr_enable !== 1'b1 || RD !== 4'd5 || WD !== 32'hDEADBEEF) begin
      bad++; $display("FAIL alu_n1 got we=%b RD=%0d WD=%h exp we=1 RD=5 WD=deadbeef", wr_enable, RD, WD);
    end
    cycle();
    total++;
    if (wr_enable !== 1'b0 || RD !== 4'd5) begin
      bad++; $display("FAIL alu_n2 got we=%b RD=%0d exp we=0 RD=5", wr_enable, RD);
    end
  endtask

  task automatic test_hazard();
    logic exp_h;
`ifdef WB_BYPASS_EN
    exp_h = 1'b0;
`else
    exp_h = 1'b1;
`endif
    RS1 = 0; RS2 = 7; RS3 = 0;
    iss_valid = 1; iss_rd = 7;
    cycle();
    iss_valid = 0;
    total++; if (hazard !== 1'b1) begin bad++; $display("FAIL haz_set got=%b exp=1", hazard); end
    mem_valid = 1; mem_rd = 7; mem_data = 32'h0000_0777;
    cycle();
    mem_valid = 0;
    cycle();
    total++;
    if (wr_enable !== 1'b1 || RD !== 4'd7 || hazard !== exp_h) begin
      bad++; $display("FAIL haz_retire got we=%b RD=%0d hz=%b exp we=1 RD=7 hz=%b", wr_enable, RD, hazard, exp_h);
    end
    cycle();
    total++; if (hazard !== 1'b0) begin bad++; $display("FAIL haz_clear got=%b exp=0", hazard); end
    iss_valid = 1; iss_rd = 7;
    cycle();
    iss_valid = 0;
    mem_valid = 1; mem_rd = 7; mem_data = 32'h0000_0778;
    cycle();
    mem_valid = 0;
    cycle();
    iss_valid = 1; iss_rd = 7;
    cycle();
    iss_valid = 0;
    total++; if (hazard !== 1'b1) begin bad++; $display("FAIL haz_setwins got=%b exp=1", hazard); end
  endtask

  task automatic test_fifo_priority();
    int ld;
    ld = 0;
    for (int c = 0; c < 12; c++) begin
      alu_valid = (c < 6); alu_rd = 4'(8 + c); alu_data = 32'hA000_0000 + c;
      mem_valid = (ld < 5); mem_rd = 4'(ld + 1); mem_data = 32'hB000_0000 + ld + 1;
      cycle();
      if (last_acc) ld++;
      if (c == 3) begin
        total++;
        if (q_count !== 3'd4 || mem_ready !== 1'b0) begin
          bad++; $display("FAIL fifo_full got q=%0d rdy=%b exp q=4 rdy=0", q_count, mem_ready);
        end
      end
      if (c >= 6 && c <= 10) begin
        total++;
        if (wr_enable !== 1'b1 || RD !== 4'(c - 5)) begin
          bad++; $display("FAIL fifo_order got we=%b RD=%0d exp we=1 RD=%0d", wr_enable, RD, c - 5);
        end
      end
    end
    idle_inputs();
    total++; if (q_count !== 3'd0) begin bad++; $display("FAIL fifo_drain got=%0d exp=0", q_count); end
  endtask

  task automatic test_dest0();
    alu_valid = 1; alu_rd = 0; alu_data = 32'h1234;
    cycle();
    alu_valid = 0;
    total++; if (wr_enable !== 1'b0) begin bad++; $display("FAIL dest0_alu got=%b exp=0", wr_enable); end
    mem_valid = 1; mem_rd = 0; mem_data = 32'h55;
    cycle();
    mem_valid = 0;
    total++; if (q_count !== 3'd1) begin bad++; $display("FAIL dest0_push got=%0d exp=1", q_count); end
    cycle();
    total++;
    if (q_count !== 3'd0 || wr_enable !== 1'b0) begin
      bad++; $display("FAIL dest0_pop got q=%0d we=%b exp q=0 we=0", q_count, wr_enable);
    end
  endtask

  task automatic test_flush();
    RS1 = 3; RS2 = 6; RS3 = 9;
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1; alu_rd = 9; alu_data = 32'hC000_0000 + i;
      mem_valid = 1; mem_rd = 4'(i + 1); mem_data = 32'hD000_0000 + i;
      iss_valid = (i == 0); iss_rd = 3;
      cycle();
    end
    iss_valid = 0;
    total++;
    if (q_count !== 3'd4 || mem_ready !== 1'b0 || hazard !== 1'b1) begin
      bad++; $display("FAIL flush_pre got q=%0d rdy=%b hz=%b exp q=4 rdy=0 hz=1", q_count, mem_ready, hazard);
    end
    flush = 1; iss_valid = 1; iss_rd = 6;
    cycle();
    idle_inputs();
    total++;
    if (q_count !== 3'd0 || mem_ready !== 1'b1 || hazard !== 1'b0 || wr_enable !== 1'b0) begin
      bad++; $display("FAIL flush_post got q=%0d rdy=%b hz=%b we=%b exp q=0 rdy=1 hz=0 we=0",
                      q_count, mem_ready, hazard, wr_enable);
    end
    repeat (3) cycle();
  endtask

`ifdef WB_BYPASS_EN
  task automatic test_bypass();
    RS1 = 0; RS2 = 0; RS3 = 0;
    iss_valid = 1; iss_rd = 3;
    cycle();
    iss_valid = 0;
    alu_valid = 1; alu_rd = 3; alu_data = 32'h33;
    cycle();
    alu_valid = 0;
    RS1 = 3; RS3 = 3;
    #1;
    total++;
    if (byp_sel !== 3'b101 || hazard !== 1'b0 || wr_enable !== 1'b1) begin
      bad++; $display("FAIL bypass got byp=%b hz=%b we=%b exp byp=101 hz=0 we=1", byp_sel, hazard, wr_enable);
    end
    cycle();
    total++;
    if (byp_sel !== 3'b000 || hazard !== 1'b0) begin
      bad++; $display("FAIL bypass_after got byp=%b hz=%b exp byp=000 hz=0", byp_sel, hazard);
    end
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 80; c++) begin
      alu_valid = ($urandom_range(0, 99) < 35);
      alu_rd    = 4'($urandom_range(0, 15));
      alu_data  = $urandom;
      mem_valid = ($urandom_range(0, 99) < 60);
      mem_rd    = 4'($urandom_range(0, 15));
      mem_data  = $urandom;
      iss_valid = ($urandom_range(0, 99) < 30);
      iss_rd    = 4'($urandom_range(0, 15));
      RS1 = 4'($urandom_range(0, 15));
      RS2 = 4'($urandom_range(0, 15));
      RS3 = 4'($urandom_range(0, 15));
      flush = ($urandom_range(0, 99) < 4);
      cycle();
    end
    idle_inputs();
    repeat (6) cycle();
  endtask

  task automatic test_reset_mid();
    RS1 = 4; RS2 = 0; RS3 = 0;
    alu_valid = 1; alu_rd = 2; alu_data = 32'h22;
    mem_valid = 1; mem_rd = 1; mem_data = 32'h11;
    iss_valid = 1; iss_rd = 4;
    repeat (2) cycle();
    idle_inputs();
    rst = 0;
    #1;
    total++;
    if (q_count !== 3'd0 || wr_enable !== 1'b0 || RD !== 4'd0 || WD !== 32'd0 || hazard !== 1'b0) begin
      bad++; $display("FAIL rst_mid got q=%0d we=%b RD=%0d WD=%h hz=%b exp all 0",
                      q_count, wr_enable, RD, WD, hazard);
    end
    model_reset();
    @(posedge clk); #1;
    rst = 1;
    repeat (4) cycle();
  endtask

  initial begin
    test_reset();
    test_alu_single();
    test_hazard();
    test_fifo_priority();
    test_dest0();
    test_flush();
`ifdef WB_BYPASS_EN
    test_bypass();
`endif
    test_random();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL final_queue got %0d outstanding writes exp 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
